// File: rtl/dac7821_write_sequencer.sv
// dac7821_write_sequencer: coalesces CPU writes into per-channel shadows and replays them to DAC7821 devices one at a time.
module dac7821_write_sequencer #(
  parameter int SETUP_CYC = 1,
  parameter int CS_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [11:0] DECODE_IN,
  input  logic [11:0] DATA_IN,
  input  logic        WR_STB,
  output logic [11:0] DAC_DB,
  output logic [6:0]  DAC_CS_N,
  output logic        DAC_RW_N,
  output logic        BUSY,
  output logic        DONE,
  output logic [6:0]  PEND
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  sel, pick;
  logic [11:0] shadow [7];
  logic [6:0]  set, clr;
  assign set = WR_STB ? DECODE_IN[6:0] : 7'h00;
  assign clr = (state == IDLE && |PEND) ? 7'b1 << pick : 7'h00;
  always_comb begin
    pick = 3'd0;
    for (int i = 6; i >= 0; i--) if (PEND[i]) pick = 3'(i);
  end
  // A new write to the channel being cleared wins, so it gets its own later transfer.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      sel      <= 3'd0;
      DAC_DB   <= 12'h000;
      DAC_CS_N <= 7'h7F;
      DAC_RW_N <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PEND     <= 7'h00;
      for (int i = 0; i < 7; i++) shadow[i] <= 12'h000;
    end else begin
      DONE <= 1'b0;
      PEND <= (PEND & ~clr) | set;
      for (int i = 0; i < 7; i++) if (set[i]) shadow[i] <= DATA_IN;
      case (state)
        IDLE: if (|PEND) begin
          state    <= SETUP;
          sel      <= pick;
          DAC_DB   <= shadow[pick];
          DAC_RW_N <= 1'b0;
          BUSY     <= 1'b1;
          cnt      <= 4'(SETUP_CYC - 1);
        end
        SETUP: if (cnt == 4'd0) begin
          state    <= STROBE;
          DAC_CS_N <= ~(7'b1 << sel);
          cnt      <= 4'(CS_CYC - 1);
        end else cnt <= cnt - 4'd1;
        STROBE: if (cnt == 4'd0) begin
          state    <= HOLD;
          DAC_CS_N <= 7'h7F;
          cnt      <= 4'(HOLD_CYC - 1);
        end else cnt <= cnt - 4'd1;
        HOLD: if (cnt == 4'd0) begin
          state    <= IDLE;
          DAC_RW_N <= 1'b1;
          BUSY     <= 1'b0;
          DONE     <= 1'b1;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac7821_write_sequencer.sv
// tb_dac7821_write_sequencer: scoreboard bench; expected transfers queued at stimulus, checked when chip-select releases.
module tb_dac7821_write_sequencer;
  logic        Clock = 0, Reset_n = 0, WR_STB = 0;
  logic [11:0] DECODE_IN = '0, DATA_IN = '0, DAC_DB;
  logic [6:0]  DAC_CS_N, PEND;
  logic        DAC_RW_N, BUSY, DONE;
  int compared = 0, mismatched = 0, done_cnt = 0, xfer_cnt = 0;
  logic [14:0] sb [$];
  dac7821_write_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .DECODE_IN(DECODE_IN), .DATA_IN(DATA_IN), .WR_STB(WR_STB),
    .DAC_DB(DAC_DB), .DAC_CS_N(DAC_CS_N), .DAC_RW_N(DAC_RW_N), .BUSY(BUSY), .DONE(DONE), .PEND(PEND)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic        in_strobe = 0;
  logic [2:0]  m_ch;
  logic [11:0] m_db;
  int          s_len = 0, b_len = 0;
  always @(posedge Clock) begin
    #1;
    if (!Reset_n) begin
      in_strobe = 0; s_len = 0; b_len = 0;
    end else begin
      if (DONE) done_cnt++;
      if (BUSY) b_len++;
      else if (b_len != 0) begin
        check("busy_len", b_len, 4);
        check("done_at_end", DONE, 1);
        check("rw_idle", DAC_RW_N, 1);
        b_len = 0;
      end
      if (DAC_CS_N != 7'h7F) begin
        check("cs_onehot", $countones(~DAC_CS_N), 1);
        check("rw_strobe", DAC_RW_N, 0);
        if (!in_strobe) begin
          in_strobe = 1; s_len = 1; m_db = DAC_DB;
          for (int i = 6; i >= 0; i--) if (!DAC_CS_N[i]) m_ch = 3'(i);
        end else begin
          s_len++;
          if (DAC_DB !== m_db) check("db_stable", DAC_DB, m_db);
        end
      end else if (in_strobe) begin
        in_strobe = 0;
        check("cs_len", s_len, 2);
        check("db_hold", DAC_DB, m_db);
        if (sb.size() == 0) check("unexpected_xfer", {m_ch, m_db}, 0);
        else begin
          logic [14:0] e;
          e = sb.pop_front();
          check("xfer_ch", m_ch, e[14:12]);
          check("xfer_db", m_db, e[11:0]);
          xfer_cnt++;
        end
      end
    end
  end
  task automatic wr(input logic [11:0] dec, input logic [11:0] data);
    @(negedge Clock);
    WR_STB = 1; DECODE_IN = dec; DATA_IN = data;
    @(negedge Clock);
    WR_STB = 0; DECODE_IN = '0; DATA_IN = '0;
  endtask
  task automatic push(input logic [2:0] ch, input logic [11:0] data);
    sb.push_back({ch, data});
  endtask
  task automatic wait_cs(input int ch);
    int n = 0;
    do begin @(posedge Clock); #1; n++; end while (DAC_CS_N[ch] && n < 100);
    if (DAC_CS_N[ch]) check("wait_cs_timeout", DAC_CS_N, ~(7'b1 << ch));
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(posedge Clock); #2; n++; end while ((BUSY || PEND != 0 || sb.size() != 0) && n < 300);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_done_cnt"}, done_cnt, xfer_cnt);
    check({tag, "_pend"}, PEND, 0);
  endtask
  initial begin
    repeat (2) @(posedge Clock);
    #1;
    check("rst_cs", DAC_CS_N, 7'h7F);
    check("rst_rw", DAC_RW_N, 1);
    check("rst_db", DAC_DB, 0);
    check("rst_busy_done", {BUSY, DONE}, 0);
    check("rst_pend", PEND, 0);
    wr(12'h001, 12'hABC);
    check("wr_in_reset_pend", PEND, 0);
    @(negedge Clock) Reset_n = 1;
    push(0, 12'hABC);
    wr(12'h001, 12'hABC);
    wait_idle("single");
    check("single_db_idle", DAC_DB, 12'hABC);
    push(2, 12'h123); push(5, 12'h123);
    wr(12'h024, 12'h123);
    begin
      int n = 0;
      do begin @(posedge Clock); #1; n++; end while (!DONE && n < 100);
      check("b2b_done_seen", DONE, 1);
      check("b2b_pend5", PEND, 7'h20);
      @(posedge Clock); #1;
      check("b2b_gap", BUSY, 1);
    end
    wait_idle("multi");
    push(0, 12'h777); push(3, 12'h222);
    wr(12'h001, 12'h777);
    wr(12'h008, 12'h111);
    wr(12'h008, 12'h222);
    wait_idle("coalesce");
    push(1, 12'h0F0); push(1, 12'h555);
    wr(12'h002, 12'h0F0);
    wait_cs(1);
    wr(12'h002, 12'h555);
    wait_idle("inflight");
    wr(12'h800, 12'h999);
    repeat (3) begin
      @(posedge Clock); #1;
      check("nochan_busy_cs", {BUSY, DAC_CS_N}, {1'b0, 7'h7F});
    end
    check("nochan_pend", PEND, 0);
    push(4, 12'h4A4);
    wr(12'h050, 12'h4A4);
    wait_cs(4);
    @(negedge Clock) Reset_n = 0;
    @(posedge Clock); #1;
    check("abort_cs", DAC_CS_N, 7'h7F);
    check("abort_rw", DAC_RW_N, 1);
    check("abort_db", DAC_DB, 0);
    check("abort_pend", PEND, 0);
    check("abort_busy_done", {BUSY, DONE}, 0);
    sb.delete();
    @(negedge Clock) Reset_n = 1;
    repeat (4) begin
      @(posedge Clock); #1;
      check("post_abort_quiet", {DONE, BUSY, DAC_CS_N}, {2'b00, 7'h7F});
    end
    wait_idle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dac7821_write_sequencer.md
DAC7821_WRITE_SEQUENCER -- requirements
Module: dac7821_write_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 1, number of cycles data/R-W are driven before chip-select assertion (range 1-15).
REQ-002 Parameter CS_CYC, default 2, number of cycles chip-select is held low (range 1-15).
REQ-003 Parameter HOLD_CYC, default 1, number of cycles data is held after chip-select release (range 1-15).
REQ-004 Clock  input  1  single system clock; all logic on rising edge.
REQ-005 Reset_n  input  1  reset, synchronous, active-low.
REQ-006 DECODE_IN  input  12  one-hot register enables from address decoder; bits 0-6 select DAC7821 channels 0-6; bits 7-11 are not DAC channels.
REQ-007 DATA_IN  input  12  CPU write data, lower 12 bits.
REQ-008 WR_STB  input  1  single-cycle write qualifier; DECODE_IN/DATA_IN are sampled only when WR_STB=1.
REQ-009 DAC_DB  output  12  shared parallel data bus to all DAC7821 devices.
REQ-010 DAC_CS_N  output  7  per-device chip-select, active-low.
REQ-011 DAC_RW_N  output  1  shared R/W line; 0 = write, 1 = idle/read.
REQ-012 BUSY  output  1  high while a transfer is in progress (any state other than IDLE).
REQ-013 DONE  output  1  one-cycle pulse when a transfer completes.
REQ-014 PEND  output  7  per-channel pending flags.

Function
REQ-015 On WR_STB=1, each channel n (0-6) with DECODE_IN[n]=1 SHALL load DATA_IN into shadow[n] and set PEND[n] at the same edge.
REQ-016 DECODE_IN bits 7-11 SHALL be ignored; WR_STB with no channel bit set causes no state change.
REQ-017 Multi-hot DECODE_IN[6:0] SHALL load the same data into every selected shadow and set every corresponding pending flag.
REQ-018 A write to a channel already pending SHALL overwrite its shadow; one transfer only, carrying the latest value (coalescing).
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-020 IDLE: if any PEND set, select the lowest-index pending channel, copy its shadow to DAC_DB, clear its PEND bit, go to SETUP at the next edge; otherwise remain.
REQ-021 SETUP: DAC_RW_N=0, all DAC_CS_N=1, DAC_DB stable; after SETUP_CYC cycles go to STROBE.
REQ-022 STROBE: DAC_CS_N[sel]=0, others 1, DAC_RW_N=0; after CS_CYC cycles go to HOLD.
REQ-023 HOLD: all DAC_CS_N=1, DAC_RW_N=0, DAC_DB held; after HOLD_CYC cycles go to IDLE with DONE=1 for exactly that one cycle in IDLE.
REQ-024 In IDLE, DAC_RW_N SHALL be 1 and DAC_DB SHALL hold its last transferred value.
REQ-025 DAC_DB SHALL NOT change from SETUP entry to HOLD exit.
REQ-026 At most one DAC_CS_N bit SHALL be low in any cycle.
REQ-027 A write to the channel in flight SHALL not alter the in-flight DAC_DB; it sets PEND again and produces a later transfer.
REQ-028 A write and a PEND clear for the same channel at the same edge: the set SHALL win (PEND=1).
REQ-029 Transfer length SHALL be exactly SETUP_CYC+CS_CYC+HOLD_CYC cycles in non-IDLE states, plus one IDLE arbitration cycle between back-to-back transfers.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 With Reset_n=0 at an edge: DAC_CS_N=7'h7F, DAC_RW_N=1, DAC_DB=0, BUSY=0, DONE=0, PEND=0, all shadows=0, FSM=IDLE.
REQ-032 Reset mid-transfer SHALL abort the transfer; chip-select deasserts at that same edge and no DONE pulse is produced.
REQ-033 WR_STB SHALL be ignored while Reset_n=0.

Verification
REQ-034 Single write, DECODE_IN=12'h001, DATA_IN=12'hABC, defaults -> DAC_DB=12'hABC, DAC_CS_N[0] low for exactly 2 cycles, BUSY high 4 cycles, one DONE pulse, PEND=0 afterwards.
REQ-035 Same-cycle writes to channels 5 and 2 (DECODE_IN=12'h024, DATA_IN=12'h123) -> channel 2 transferred first, then channel 5, both with 12'h123, with one IDLE cycle between.
REQ-036 Two writes to channel 3 (12'h111 then 12'h222) while channel 0 is in flight -> only one channel-3 transfer, with DAC_DB=12'h222.
REQ-037 Write 12'h555 to channel 1 during its own STROBE state -> the in-flight transfer keeps its original value; a second transfer with 12'h555 follows.
REQ-038 DECODE_IN=12'h800 with WR_STB=1 -> no PEND set, BUSY stays 0, DAC_CS_N stays 7'h7F.
REQ-039 Reset_n low during STROBE of channel 4 -> at that edge DAC_CS_N=7'h7F, DAC_RW_N=1, DAC_DB=0, PEND=0, no DONE pulse.
